nor_unit_arbiter: RTL

- Shares one registered WIDTH-bit bitwise NOR unit (y = ~(a|b)) among N_REQ requesters.
- Round-robin arbitration, per-requester operand capture, one-hot grant pulse, tagged result pulse, saturating completed-operation counter.
- Sits between several logic-exercise front ends and the single NOR datapath in the logic-gates library.

---
 rtl/nor_unit_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/nor_unit_arbiter.sv
// -----------------------------------------------------------------------------
// nor_unit_arbiter
//
// Shares a single registered WIDTH-bit NOR unit (y = ~(a | b)) among N_REQ
// requesters using round-robin arbitration. Each operation takes three cycles:
// IDLE (arbitrate + capture operands), GRANT (grant pulse, compute), RESP
// (result strobe, count the completed operation).
//
// Handshake (valid/ready): a requester raises req[i] (its "valid") and holds
// it with stable operands until it sees gnt[i] (the "ready"). Operands are
// captured on the same edge that raises gnt[i]. The requester must drop req[i]
// in the cycle after it sees gnt[i]; a req still high when IDLE is re-entered
// is a new request. req and operands are ignored outside IDLE.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   req        per-requester request level
//   a_in,b_in  packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt        one-hot grant pulse (registered)
//   y          NOR result, valid while res_valid, held afterwards
//   res_valid  one-cycle result strobe (registered)
//   res_id     requester index owning y
//   busy       high whenever the FSM is not IDLE
//   ops_done   saturating count of completed operations
//   dbg_state  FSM state for observation (0 IDLE, 1 GRANT, 2 RESP)
// -----------------------------------------------------------------------------
module nor_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       y,
    output logic                   res_valid,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy,
    output logic [CNT_W-1:0]       ops_done,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [ID_W-1:0]  r_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [ID_W-1:0]  r_id;
    logic [N_REQ-1:0] r_gnt;
    logic [WIDTH-1:0] r_y;
    logic             r_res_valid;
    logic [ID_W-1:0]  r_res_id;
    logic [CNT_W-1:0] r_ops_done;

    logic             w_any;
    logic             w_found;
    logic [ID_W-1:0]  w_win;
    logic [ID_W:0]    w_sum;
    logic [N_REQ-1:0] w_onehot;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    // Round-robin search: examine last+1, last+2, ... last+N_REQ (mod N_REQ)
    // and take the first requester found. The sum is one bit wider than the
    // index so the wrap can be done by a single conditional subtract.
    always_comb begin
        w_any   = |req;
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_sum = {1'b0, r_last} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(N_REQ);
            end
            if (!w_found && req[w_sum[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[ID_W-1:0];
            end
        end
    end

    // Winner's operand slices and one-hot grant vector.
    always_comb begin
        w_a      = '0;
        w_b      = '0;
        w_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_a         = a_in[i*WIDTH +: WIDTH];
                w_b         = b_in[i*WIDTH +: WIDTH];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // FSM: next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_next_state = ST_GRANT;
            ST_GRANT: w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath and registered outputs. Reset aborts any operation in flight:
    // nothing is strobed and nothing is counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last      <= ID_W'(N_REQ - 1);
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_gnt       <= '0;
            r_y         <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_ops_done  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt  <= w_onehot;
                        r_a    <= w_a;
                        r_b    <= w_b;
                        r_id   <= w_win;
                        r_last <= w_win;
                    end
                end
                ST_GRANT: begin
                    r_gnt       <= '0;
                    r_y         <= ~(r_a | r_b);
                    r_res_id    <= r_id;
                    r_res_valid <= 1'b1;
                end
                ST_RESP: begin
                    r_res_valid <= 1'b0;
                    if (r_ops_done != {CNT_W{1'b1}}) begin
                        r_ops_done <= r_ops_done + 1'b1;
                    end
                end
                default: begin
                    r_gnt       <= '0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign y         = r_y;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign busy      = (r_state != ST_IDLE);
    assign ops_done  = r_ops_done;
    assign dbg_state = r_state;

endmodule
